gen_fifo_ctrl: RTL and testbench
================================

GEN_FIFO_CTRL -- requirements
Module: gen_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter `PTR_W`, default 4, giving the pointer width in bits; maximum depth is 2^PTR_W.
REQ-002 The block SHALL have the following ports, one per line as: name  direction  width  meaning.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `lim`  in  PTR_W  last valid entry index; depth = lim+1.
- `af_th`  in  PTR_W+1  almost-full threshold, in entries.
- `clr`  in  1  synchronous clear of all state.
- `push`  in  1  write request.
- `pop`  in  1  read request.
- `wr_en`  out  1  write strobe to storage.
- `wr_addr`  out  PTR_W  write address, equal to the write pointer.
- `rd_en`  out  1  read strobe to storage.
- `rd_addr`  out  PTR_W  read address, equal to the read pointer.
- `occ`  out  PTR_W+1  number of stored entries.
- `full`  out  1  occ == lim+1.
- `empty`  out  1  occ == 0.
- `almost_full`  out  1  occ >= af_th.
- `ovf`  out  1  sticky overflow error.
- `udf`  out  1  sticky underflow error.

Function
REQ-003 Push acceptance SHALL be push_acc = push & ~full & ~clr.
REQ-004 Pop acceptance SHALL be pop_acc = pop & ~empty & ~clr.
REQ-005 Both accept terms SHALL use `full`/`empty` from registered state only; a pop in the same cycle SHALL NOT free space for a push while full.
REQ-006 `wr_en` SHALL equal push_acc and `rd_en` SHALL equal pop_acc; both are combinational, same cycle, zero latency.
REQ-007 `wr_addr`/`rd_addr` SHALL be the registered write/read pointers.
REQ-008 Pointer advance: on accept, the next pointer SHALL be 0 if ptr >= lim, else ptr+1 (wrap at lim); without accept the pointer holds.
REQ-009 Occupancy SHALL update in the cycle after the accept (registered):
- +1 on push_acc & ~pop_acc.
- -1 on pop_acc & ~push_acc.
- unchanged when both or neither are accepted.
REQ-010 `occ` SHALL be PTR_W+1 bits wide and never wrap; it stays within 0..lim+1 by construction of REQ-003/REQ-004.
REQ-011 `full`, `empty` and `almost_full` SHALL be combinational decodes of registered `occ` against the current `lim`/`af_th`; `af_th` = 0 SHALL force `almost_full` = 1.
REQ-012 `ovf` SHALL set in the cycle after push & full & ~clr, and hold until `clr` or reset.
REQ-013 `udf` SHALL set in the cycle after pop & empty & ~clr, and hold until `clr` or reset.
REQ-014 `clr` SHALL override push/pop:
- next cycle: pointers = 0, `occ` = 0, `ovf` = `udf` = 0.
- during the `clr` cycle: `wr_en` = `rd_en` = 0.
REQ-015 `lim` SHALL only be changed while `empty` = 1 and pointers are 0 (after `clr`); otherwise `full`/`occ` agreement with storage is not guaranteed, but pointers SHALL still obey REQ-008 (a pointer > lim wraps to 0 on its next advance).
REQ-016 Simultaneous push and pop while empty SHALL accept the push only; `udf` SHALL set.
REQ-017 Simultaneous push and pop while full SHALL accept the pop only; `ovf` SHALL set.

Reset
REQ-018 With `rst_n` = 0 at a clock edge, the next cycle SHALL show:
- pointers = 0, `occ` = 0, `empty` = 1, `full` = 0, `ovf` = 0, `udf` = 0.
- `almost_full` = (`af_th` == 0).
REQ-019 While `rst_n` = 0, `wr_en` and `rd_en` are don't-care; state SHALL NOT advance.
REQ-020 Reset SHALL take priority over `clr`, push and pop, including mid-operation with the FIFO partially full.

Verification (lim = 3, af_th = 3, PTR_W = 4 unless stated)
REQ-021 The bench SHALL push for 5 consecutive cycles from empty:
- `wr_en` high for 4 cycles, with `wr_addr` 0,1,2,3.
- `occ` goes 1,2,3,4; `almost_full` rises at occ = 3; `full` rises at occ = 4.
- the 5th push sets `ovf` and leaves `occ` at 4.
REQ-022 From full, the bench SHALL pop 5 times:
- `rd_addr` 0,1,2,3.
- `occ` 3,2,1,0.
- the 5th pop sets `udf` and leaves `rd_addr` at 0.
REQ-023 The bench SHALL push and pop together with occ = 2 for 6 cycles:
- `occ` stays 2 throughout.
- both pointers wrap 3 -> 0.
- `wr_addr` - `rd_addr` = 2 mod 4 on every cycle.
REQ-024 The bench SHALL push and pop together while empty, then while full:
- empty case: push only accepted, `occ` -> 1, `udf` set.
- full case: pop only accepted, `occ` -> 3, `ovf` set.
REQ-025 The bench SHALL assert `clr` with push = pop = 1 at occ = 2 and `ovf` = 1:
- same cycle: `wr_en` = `rd_en` = 0.
- next cycle: occ = 0, pointers = 0, `ovf` = 0.
REQ-026 The bench SHALL assert `rst_n` low for 1 cycle at occ = 3, then lim = 15 (after reset), push 16:
- after reset: `empty` = 1, `occ` = 0.
- `full` rises at occ = 16 and `wr_addr` wraps 15 -> 0.

Source files
------------

// File: rtl/gen_fifo_ctrl.sv
// FIFO pointer/occupancy controller with a run-time depth limit, almost-full
// threshold and sticky overflow/underflow flags. Storage is external; this
// block generates the write/read strobes and addresses for it.
module gen_fifo_ctrl #(
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PTR_W-1:0] lim,
  input  logic [PTR_W:0]   af_th,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  output logic             wr_en,
  output logic [PTR_W-1:0] wr_addr,
  output logic             rd_en,
  output logic [PTR_W-1:0] rd_addr,
  output logic [PTR_W:0]   occ,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             ovf,
  output logic             udf
);

  localparam logic [PTR_W:0]   OCC_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_ptr_nx, rd_ptr_nx;
  logic [PTR_W:0]   occ_q, occ_nx;
  logic [PTR_W:0]   depth;
  logic             ovf_q, udf_q;
  logic             push_acc, pop_acc;

  // Status decode from registered occupancy and the acceptance strobes
  always_comb begin
    depth       = {1'b0, lim} + OCC_ONE;
    full        = (occ_q == depth);
    empty       = (occ_q == '0);
    almost_full = (occ_q >= af_th);
    push_acc    = push & ~full & ~clr;
    pop_acc     = pop & ~empty & ~clr;
    wr_en       = push_acc;
    rd_en       = pop_acc;
    wr_addr     = wr_ptr;
    rd_addr     = rd_ptr;
    occ         = occ_q;
    ovf         = ovf_q;
    udf         = udf_q;
  end

  // Next pointer and occupancy values; pointers wrap at lim (a pointer left
  // above a reduced lim wraps to 0 on its next advance)
  always_comb begin
    wr_ptr_nx = wr_ptr;
    rd_ptr_nx = rd_ptr;
    occ_nx    = occ_q;
    if (push_acc)
      wr_ptr_nx = (wr_ptr >= lim) ? '0 : wr_ptr + PTR_ONE;
    if (pop_acc)
      rd_ptr_nx = (rd_ptr >= lim) ? '0 : rd_ptr + PTR_ONE;
    case ({push_acc, pop_acc})
      2'b10:   occ_nx = occ_q + OCC_ONE;
      2'b01:   occ_nx = occ_q - OCC_ONE;
      default: occ_nx = occ_q;
    endcase
  end

  // State registers: reset beats clear, clear beats push/pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nx;
      rd_ptr <= rd_ptr_nx;
      occ_q  <= occ_nx;
      if (push & full)
        ovf_q <= 1'b1;
      if (pop & empty)
        udf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gen_fifo_ctrl.sv
// Self-checking bench for gen_fifo_ctrl: directed scenarios plus randomized
// traffic, all checked against a behavioural model of the FIFO counters.
module tb_gen_fifo_ctrl;

  localparam int PTR_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [PTR_W-1:0] lim = 4'd3;
  logic [PTR_W:0]   af_th = 5'd3;
  logic             clr = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic             wr_en, rd_en;
  logic [PTR_W-1:0] wr_addr, rd_addr;
  logic [PTR_W:0]   occ;
  logic             full, empty, almost_full, ovf, udf;

  gen_fifo_ctrl #(.PTR_W(PTR_W)) dut (
    .clk(clk), .rst_n(rst_n), .lim(lim), .af_th(af_th), .clr(clr),
    .push(push), .pop(pop), .wr_en(wr_en), .wr_addr(wr_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .occ(occ), .full(full),
    .empty(empty), .almost_full(almost_full), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: entry count, pointer positions and sticky errors
  int m_wp, m_rp, m_occ;
  bit m_ovf, m_udf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_full();
    return m_occ == int'(lim) + 1;
  endfunction

  function automatic bit m_empty();
    return m_occ == 0;
  endfunction

  task automatic check_outputs(input bit in_rst);
    if (!in_rst) begin
      chk("wr_en", wr_en, push && !m_full() && !clr);
      chk("rd_en", rd_en, pop && !m_empty() && !clr);
    end
    chk("wr_addr", wr_addr, m_wp);
    chk("rd_addr", rd_addr, m_rp);
    chk("occ", occ, m_occ);
    chk("full", full, m_full());
    chk("empty", empty, m_empty());
    chk("almost_full", almost_full, m_occ >= int'(af_th));
    chk("ovf", ovf, m_ovf);
    chk("udf", udf, m_udf);
  endtask

  task automatic drive(input bit p, input bit q, input bit c);
    push = p;
    pop  = q;
    clr  = c;
    #1;
    check_outputs(!rst_n);
  endtask

  task automatic tick();
    bit pa, qa;
    int nwp, nrp, nocc;
    bit novf, nudf;
    nwp = m_wp; nrp = m_rp; nocc = m_occ; novf = m_ovf; nudf = m_udf;
    if (!rst_n || clr) begin
      nwp = 0; nrp = 0; nocc = 0; novf = 0; nudf = 0;
    end else begin
      pa = push && !m_full();
      qa = pop && !m_empty();
      if (push && m_full())  novf = 1;
      if (pop && m_empty())  nudf = 1;
      if (pa) nwp = (m_wp >= int'(lim)) ? 0 : m_wp + 1;
      if (qa) nrp = (m_rp >= int'(lim)) ? 0 : m_rp + 1;
      nocc = m_occ + int'(pa) - int'(qa);
    end
    @(posedge clk);
    m_wp = nwp; m_rp = nrp; m_occ = nocc; m_ovf = novf; m_udf = nudf;
    #1;
    check_outputs(!rst_n);
  endtask

  initial begin
    m_wp = 0; m_rp = 0; m_occ = 0; m_ovf = 0; m_udf = 0;
    // Reset out of power-up
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_occ", occ, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_udf", udf, 0);

    // Fill past full
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0);
      chk("r21_wen", wr_en, i < 4);
      if (i < 4) chk("r21_waddr", wr_addr, i);
      tick();
      chk("r21_occ", occ, (i < 4) ? i + 1 : 4);
      chk("r21_af", almost_full, i >= 2);
      chk("r21_full", full, i >= 3);
      chk("r21_ovf", ovf, i == 4);
    end

    // Drain past empty
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0);
      chk("r22_ren", rd_en, i < 4);
      if (i < 4) chk("r22_raddr", rd_addr, i);
      tick();
      chk("r22_occ", occ, (i < 4) ? 3 - i : 0);
      chk("r22_udf", udf, i == 4);
    end
    chk("r22_raddr_end", rd_addr, 0);

    // Steady push+pop at occupancy 2 across the wrap point
    drive(0, 0, 1); tick();
    drive(1, 0, 0); tick();
    drive(1, 0, 0); tick();
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 0);
      chk("r23_dist", (wr_addr - rd_addr) & 4'd3, 2);
      tick();
      chk("r23_occ", occ, 2);
    end

    // Push+pop while empty, then while full
    drive(0, 0, 1); tick();
    drive(1, 1, 0);
    chk("r24e_wen", wr_en, 1);
    chk("r24e_ren", rd_en, 0);
    tick();
    chk("r24e_occ", occ, 1);
    chk("r24e_udf", udf, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0); tick();
    end
    chk("r24f_full", full, 1);
    drive(1, 1, 0);
    chk("r24f_wen", wr_en, 0);
    chk("r24f_ren", rd_en, 1);
    tick();
    chk("r24f_occ", occ, 3);
    chk("r24f_ovf", ovf, 1);

    // Clear overriding push+pop at occupancy 2 with ovf set
    drive(0, 1, 0); tick();
    chk("r25_pre_occ", occ, 2);
    chk("r25_pre_ovf", ovf, 1);
    drive(1, 1, 1);
    chk("r25_wen", wr_en, 0);
    chk("r25_ren", rd_en, 0);
    tick();
    chk("r25_occ", occ, 0);
    chk("r25_wp", wr_addr, 0);
    chk("r25_rp", rd_addr, 0);
    chk("r25_ovf", ovf, 0);

    // Reset mid-operation, then full-depth run with lim = 15
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0); tick();
    end
    rst_n = 1'b0;
    drive(1, 1, 1);
    tick();
    rst_n = 1'b1;
    chk("r26_empty", empty, 1);
    chk("r26_occ", occ, 0);
    lim = 4'd15;
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 0);
      chk("r26_waddr", wr_addr, i);
      tick();
      chk("r26_full", full, i == 15);
    end
    chk("r26_wrap", wr_addr, 0);

    // Randomized traffic with varying limits, thresholds, clears and resets
    for (int seg = 0; seg < 10; seg++) begin
      int pp, qp;
      drive(0, 0, 1); tick();
      lim   = 4'($urandom_range(0, 15));
      af_th = 5'($urandom_range(0, 16));
      pp = $urandom_range(20, 80);
      qp = $urandom_range(20, 80);
      for (int c = 0; c < 250; c++) begin
        bit p, q, k;
        p = $urandom_range(0, 99) < pp;
        q = $urandom_range(0, 99) < qp;
        k = $urandom_range(0, 99) == 0;
        if ($urandom_range(0, 19) == 0) af_th = 5'($urandom_range(0, 16));
        rst_n = ($urandom_range(0, 149) != 0);
        drive(p, q, k);
        tick();
        rst_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
